// File: rtl/csc_pkg.sv
// rtl/csc_pkg.sv - coefficient matrices, mode encoding and W-scaled offsets for csc_pipe
package csc_pkg;

  // 11 signed bits: the inverse matrix reaches 516
  localparam int COEF_W = 11;
  localparam int ROUND  = 128;
  localparam int SHIFT  = 8;

  typedef enum logic {
    MODE_RGB2YCC = 1'b0,
    MODE_YCC2RGB = 1'b1
  } csc_mode_e;

  typedef logic signed [COEF_W-1:0] coef_t;

  localparam coef_t FWD [3][3] = '{
    '{ 11'sd66,   11'sd129,  11'sd25 },
    '{-11'sd38,  -11'sd74,   11'sd112},
    '{ 11'sd112, -11'sd94,  -11'sd18 }
  };

  localparam coef_t INV [3][3] = '{
    '{ 11'sd298,  11'sd0,    11'sd409},
    '{ 11'sd298, -11'sd100, -11'sd208},
    '{ 11'sd298,  11'sd516,  11'sd0  }
  };

  function automatic int lo_offset(input int w);
    return 16 << (w - 8);
  endfunction

  function automatic int hi_offset(input int w);
    return 128 << (w - 8);
  endfunction

endpackage

// File: rtl/csc_pipe_if.sv
// rtl/csc_pipe_if.sv - pixel in/out bundle for csc_pipe
interface csc_pipe_if #(
  parameter int W      = 8,
  parameter int USER_W = 1
);
  logic              iValid;
  logic              iMode;
  logic [W-1:0]      iC0, iC1, iC2;
  logic [USER_W-1:0] iUser;
  logic              oValid;
  logic              oMode;
  logic [W-1:0]      oC0, oC1, oC2;
  logic [USER_W-1:0] oUser;

  modport master (
    output iValid, iMode, iC0, iC1, iC2, iUser,
    input  oValid, oMode, oC0, oC1, oC2, oUser
  );

  modport slave (
    input  iValid, iMode, iC0, iC1, iC2, iUser,
    output oValid, oMode, oC0, oC1, oC2, oUser
  );
endinterface

// File: rtl/csc_dot3.sv
// rtl/csc_dot3.sv - three-term signed MAC with rounding, floor shift, offset and clamp
module csc_dot3
  import csc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic signed [W:0]   a [3],
  input  coef_t               k [3],
  input  logic signed [W:0]   off,
  output logic        [W-1:0] y
);
  localparam int PW = W + 1 + COEF_W;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] RND  = SW'(ROUND);
  localparam logic signed [SW-1:0] YMAX = SW'((1 << W) - 1);

  logic signed [PW-1:0] p [3];
  logic signed [W:0]    off_q;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] scaled;
  logic        [W-1:0]  sat;

  always_comb begin
    sum    = SW'(p[0]) + SW'(p[1]) + SW'(p[2]) + RND;
    scaled = (sum >>> SHIFT) + SW'(off_q);
    if (scaled[SW-1])
      sat = '0;
    else if (scaled > YMAX)
      sat = '1;
    else
      sat = scaled[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p     <= '{default: '0};
      off_q <= '0;
      y     <= '0;
    end else if (ce) begin
      for (int i = 0; i < 3; i++) p[i] <= PW'(a[i]) * PW'(k[i]);
      off_q <= off;
      y     <= sat;
    end
  end

endmodule

// File: rtl/csc_pipe.sv
// rtl/csc_pipe.sv - three-stage bidirectional RGB/YCbCr converter with per-pixel mode
module csc_pipe
  import csc_pkg::*;
#(
  parameter int W      = 8,
  parameter int USER_W = 1
) (
  input logic       iClk,
  input logic       iRst,
  input logic       iCe,
  csc_pipe_if.slave bus
);
  localparam logic signed [W:0] OFF_LO = (W+1)'(lo_offset(W));
  localparam logic signed [W:0] OFF_HI = (W+1)'(hi_offset(W));

  logic              v1, v2;
  csc_mode_e         m1, m2;
  logic [USER_W-1:0] u1, u2;
  logic [W-1:0]      c1 [3];
  logic signed [W:0] a [3];
  logic [2:0][W-1:0] y;

  // Inverse mode removes the luma/chroma offsets before the products
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      a[i] = $signed({1'b0, c1[i]});
      if (m1 == MODE_YCC2RGB) a[i] = a[i] - ((i == 0) ? OFF_LO : OFF_HI);
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    coef_t             kr [3];
    logic signed [W:0] offr;

    always_comb begin
      for (int i = 0; i < 3; i++)
        kr[i] = (m1 == MODE_YCC2RGB) ? INV[r][i] : FWD[r][i];
      offr = (m1 == MODE_YCC2RGB) ? '0 : ((r == 0) ? OFF_LO : OFF_HI);
    end

    csc_dot3 #(.W(W)) u_dot (
      .clk   (iClk),
      .rst_n (iRst),
      .ce    (iCe),
      .a     (a),
      .k     (kr),
      .off   (offr),
      .y     (y[r])
    );
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      v1         <= 1'b0;
      m1         <= MODE_RGB2YCC;
      u1         <= '0;
      c1         <= '{default: '0};
      v2         <= 1'b0;
      m2         <= MODE_RGB2YCC;
      u2         <= '0;
      bus.oValid <= 1'b0;
      bus.oMode  <= 1'b0;
      bus.oUser  <= '0;
    end else if (iCe) begin
      v1         <= bus.iValid;
      m1         <= csc_mode_e'(bus.iMode);
      u1         <= bus.iUser;
      c1[0]      <= bus.iC0;
      c1[1]      <= bus.iC1;
      c1[2]      <= bus.iC2;
      v2         <= v1;
      m2         <= m1;
      u2         <= u1;
      bus.oValid <= v2;
      bus.oMode  <= m2;
      bus.oUser  <= u2;
    end
  end

  assign bus.oC0 = y[0];
  assign bus.oC1 = y[1];
  assign bus.oC2 = y[2];

endmodule
